// File: rtl/simon_game_ctrl.sv
// Simon Says game sequencer: builds the colour sequence, drives display_state, checks player presses.
// Latency: every output is a flop; a qualifying input pulse shows its effect one clk after it is sampled.
// Backpressure: none; pulses arriving in a state that does not use them are dropped, not queued.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   start_btn         1-cycle pulse, starts a game from IDLE / GAME_OVER / GAME_WIN
//   btn_valid         1-cycle pulse, player colour press (btn_colour valid alongside)
//   complete_display  1-cycle pulse from display_state when the sequence has been shown
//   rst_display       synchronous reset to display_state, high only while idle
//   en_display        one-cycle start pulse to display_state on each DISPLAY entry
//   seq_out           16 x 2-bit colour sequence, colour i at seq_out[2*i +: 2]
//   round_ctr         current round N (N+1 colours shown); holds the score after the game ends
//   input_idx         index of the next colour the player must press
//   game_over         sticky loss flag, game_win sticky win flag
//   state_out         FSM state encoding for debug LEDs
module simon_game_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES     = 2_500_000,
  parameter int unsigned MAX_ROUND      = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_btn,
  input  logic        btn_valid,
  input  logic [1:0]  btn_colour,
  input  logic        complete_display,
  output logic        rst_display,
  output logic        en_display,
  output logic [31:0] seq_out,
  output logic [3:0]  round_ctr,
  output logic [3:0]  input_idx,
  output logic        game_over,
  output logic        game_win,
  output logic [2:0]  state_out
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       LAST_RND  = 4'(MAX_ROUND);

  localparam logic [31:0] LFSR_SEED = 32'hACE1_2468;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_DISPLAY    = 3'd2,
    S_WAIT_INPUT = 3'd3,
    S_ROUND_DONE = 3'd4,
    S_GAP        = 3'd5,
    S_GAME_OVER  = 3'd6,
    S_GAME_WIN   = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [31:0]      seq_out_q, seq_out_d;
  logic [3:0]       round_ctr_q, round_ctr_d;
  logic [3:0]       input_idx_q, input_idx_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             game_over_q, game_over_d;
  logic             game_win_q, game_win_d;
  logic             en_display_q, en_display_d;
  logic             rst_display_q, rst_display_d;
  logic [1:0]       exp_colour;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      lfsr_q        <= LFSR_SEED;
      seq_out_q     <= '0;
      round_ctr_q   <= '0;
      input_idx_q   <= '0;
      timer_q       <= '0;
      gap_cnt_q     <= '0;
      game_over_q   <= 1'b0;
      game_win_q    <= 1'b0;
      en_display_q  <= 1'b0;
      rst_display_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      seq_out_q     <= seq_out_d;
      round_ctr_q   <= round_ctr_d;
      input_idx_q   <= input_idx_d;
      timer_q       <= timer_d;
      gap_cnt_q     <= gap_cnt_d;
      game_over_q   <= game_over_d;
      game_win_q    <= game_win_d;
      en_display_q  <= en_display_d;
      rst_display_q <= rst_display_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    seq_out_d   = seq_out_q;
    round_ctr_d = round_ctr_q;
    input_idx_d = input_idx_q;
    timer_d     = '0;
    gap_cnt_d   = '0;
    game_over_d = game_over_q;
    game_win_d  = game_win_q;

    // Free-running Galois LFSR; the game seed is whatever value it holds when LOAD samples it.
    lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

    exp_colour = seq_out_q[{input_idx_q, 1'b0} +: 2];

    case (state_q)
      S_IDLE: begin
        if (start_btn) state_d = S_LOAD;
      end

      S_LOAD: begin
        seq_out_d   = lfsr_q;
        round_ctr_d = '0;
        input_idx_d = '0;
        game_over_d = 1'b0;
        game_win_d  = 1'b0;
        state_d     = S_DISPLAY;
      end

      S_DISPLAY: begin
        if (complete_display) begin
          input_idx_d = '0;
          state_d     = S_WAIT_INPUT;
        end
      end

      S_WAIT_INPUT: begin
        timer_d = timer_q + TMR_W'(1);
        // A press on the timeout cycle wins over the timeout.
        if (btn_valid) begin
          if (btn_colour != exp_colour) begin
            game_over_d = 1'b1;
            state_d     = S_GAME_OVER;
          end else if (input_idx_q == round_ctr_q) begin
            state_d = S_ROUND_DONE;
          end else begin
            input_idx_d = input_idx_q + 4'd1;
            timer_d     = '0;
          end
        end else if (timer_q == TMR_LAST) begin
          game_over_d = 1'b1;
          state_d     = S_GAME_OVER;
        end
      end

      S_ROUND_DONE: begin
        if (round_ctr_q == LAST_RND) begin
          game_win_d = 1'b1;
          state_d    = S_GAME_WIN;
        end else begin
          round_ctr_d = round_ctr_q + 4'd1;
          input_idx_d = '0;
          state_d     = S_GAP;
        end
      end

      S_GAP: begin
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
        if (gap_cnt_q == GAP_LAST) state_d = S_DISPLAY;
      end

      S_GAME_OVER, S_GAME_WIN: begin
        if (start_btn) state_d = S_LOAD;
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the flops line up with the state they belong to.
    en_display_d  = (state_d == S_DISPLAY) && (state_q != S_DISPLAY);
    rst_display_d = (state_d == S_IDLE);
  end

  assign rst_display = rst_display_q;
  assign en_display  = en_display_q;
  assign seq_out     = seq_out_q;
  assign round_ctr   = round_ctr_q;
  assign input_idx   = input_idx_q;
  assign game_over   = game_over_q;
  assign game_win    = game_win_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Testbench for simon_game_ctrl with TIMEOUT_CYCLES=20, GAP_CYCLES=4, MAX_ROUND=2.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
// A table of per-cycle vectors covers a full winning game; hand sequences cover loss, timeout and reset.
module tb_simon_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_btn;
  logic        btn_valid;
  logic [1:0]  btn_colour;
  logic        complete_display;
  logic        rst_display;
  logic        en_display;
  logic [31:0] seq_out;
  logic [3:0]  round_ctr;
  logic [3:0]  input_idx;
  logic        game_over;
  logic        game_win;
  logic [2:0]  state_out;

  int checks   = 0;
  int failures = 0;

  simon_game_ctrl #(
    .TIMEOUT_CYCLES(20),
    .GAP_CYCLES    (4),
    .MAX_ROUND     (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_btn       (start_btn),
    .btn_valid       (btn_valid),
    .btn_colour      (btn_colour),
    .complete_display(complete_display),
    .rst_display     (rst_display),
    .en_display      (en_display),
    .seq_out         (seq_out),
    .round_ctr       (round_ctr),
    .input_idx       (input_idx),
    .game_over       (game_over),
    .game_win        (game_win),
    .state_out       (state_out)
  );

  always #5 clk = ~clk;

  // Reference LFSR: same seed and taps, same reset, steps on every rising edge.
  logic [31:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 32'hACE1_2468;
    else        m_lfsr <= {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  typedef struct {
    logic       st;    // start_btn
    logic       bv;    // btn_valid
    logic       bad;   // press the wrong colour instead of the expected one
    logic       cd;    // complete_display
    logic [2:0] s;     // expected state_out
    logic [3:0] rnd;   // expected round_ctr
    logic [3:0] idx;   // expected input_idx
    logic       en;    // expected en_display
    logic       ov;    // expected game_over
    logic       wn;    // expected game_win
  } vec_t;

  localparam int NV = 32;
  vec_t        tbl[NV];
  logic [31:0] exp_seq;
  logic [3:0]  cur_idx;

  function automatic vec_t mk(input logic st, input logic bv, input logic bad, input logic cd,
                              input logic [2:0] s, input logic [3:0] rnd, input logic [3:0] idx,
                              input logic en, input logic ov, input logic wn);
    vec_t v;
    v.st = st; v.bv = bv; v.bad = bad; v.cd = cd;
    v.s = s; v.rnd = rnd; v.idx = idx; v.en = en; v.ov = ov; v.wn = wn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] c);
    btn_colour = c;
    btn_valid  = 1'b1;
    cyc();
    btn_valid  = 1'b0;
  endtask

  task automatic pulse_cd();
    complete_display = 1'b1;
    cyc();
    complete_display = 1'b0;
  endtask

  // Start a game and remember the LFSR value LOAD is about to latch.
  task automatic start_game(input string nm);
    start_btn = 1'b1;
    cyc();
    start_btn = 1'b0;
    chk(nm, 64'(state_out), 64'd1);
    exp_seq = m_lfsr;
    cyc();
  endtask

  task automatic wait_state(input string nm, input logic [2:0] target, input int limit);
    for (int k = 0; k < limit && state_out != target; k++) cyc();
    chk(nm, 64'(state_out), 64'(target));
  endtask

  task automatic chk_reset(input string nm);
    chk(nm, 64'({state_out, seq_out, round_ctr, input_idx, en_display, game_over, game_win, rst_display}),
            64'({3'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}));
  endtask

  // From DISPLAY in round 0: clear round 0 and arrive in WAIT_INPUT of round 1.
  task automatic to_round1(input string nm);
    pulse_cd();
    press(exp_seq[1:0]);
    wait_state({nm, "_disp"}, 3'd2, 12);
    pulse_cd();
    chk({nm, "_wait"}, 64'({state_out, round_ctr, input_idx}), 64'({3'd3, 4'd1, 4'd0}));
  endtask

  initial begin
    //                st bv bad cd  s  rnd idx en ov wn
    tbl[0]  = mk(1, 0, 0, 0, 3'd1, 4'd0, 4'd0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 3'd2, 4'd0, 4'd0, 1, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 3'd2, 4'd0, 4'd0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 3'd2, 4'd0, 4'd0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 3'd2, 4'd0, 4'd0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 3'd2, 4'd0, 4'd0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 1, 3'd3, 4'd0, 4'd0, 0, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0, 3'd3, 4'd0, 4'd0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 1, 3'd3, 4'd0, 4'd0, 0, 0, 0);
    tbl[9]  = mk(0, 1, 0, 0, 3'd4, 4'd0, 4'd0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 3'd5, 4'd1, 4'd0, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 3'd5, 4'd1, 4'd0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 3'd5, 4'd1, 4'd0, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 3'd5, 4'd1, 4'd0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 3'd2, 4'd1, 4'd0, 1, 0, 0);
    tbl[15] = mk(0, 1, 0, 0, 3'd2, 4'd1, 4'd0, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 1, 3'd3, 4'd1, 4'd0, 0, 0, 0);
    tbl[17] = mk(0, 1, 0, 0, 3'd3, 4'd1, 4'd1, 0, 0, 0);
    tbl[18] = mk(0, 1, 0, 0, 3'd4, 4'd1, 4'd1, 0, 0, 0);
    tbl[19] = mk(0, 0, 0, 0, 3'd5, 4'd2, 4'd0, 0, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, 3'd5, 4'd2, 4'd0, 0, 0, 0);
    tbl[21] = mk(0, 0, 0, 0, 3'd5, 4'd2, 4'd0, 0, 0, 0);
    tbl[22] = mk(0, 0, 0, 0, 3'd5, 4'd2, 4'd0, 0, 0, 0);
    tbl[23] = mk(0, 0, 0, 0, 3'd2, 4'd2, 4'd0, 1, 0, 0);
    tbl[24] = mk(0, 0, 0, 1, 3'd3, 4'd2, 4'd0, 0, 0, 0);
    tbl[25] = mk(0, 1, 0, 0, 3'd3, 4'd2, 4'd1, 0, 0, 0);
    tbl[26] = mk(0, 1, 0, 0, 3'd3, 4'd2, 4'd2, 0, 0, 0);
    tbl[27] = mk(0, 1, 0, 0, 3'd4, 4'd2, 4'd2, 0, 0, 0);
    tbl[28] = mk(0, 0, 0, 0, 3'd7, 4'd2, 4'd2, 0, 0, 1);
    tbl[29] = mk(0, 1, 0, 0, 3'd7, 4'd2, 4'd2, 0, 0, 1);
    tbl[30] = mk(1, 0, 0, 0, 3'd1, 4'd2, 4'd2, 0, 0, 1);
    tbl[31] = mk(0, 0, 0, 0, 3'd2, 4'd0, 4'd0, 1, 0, 0);

    rst_n = 1'b0;
    start_btn = 1'b0;
    btn_valid = 1'b0;
    btn_colour = 2'd0;
    complete_display = 1'b0;
    exp_seq = 32'd0;
    cur_idx = 4'd0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset_values");
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Full winning game with filtered pulses sprinkled in, then a restart from GAME_WIN.
    for (int i = 0; i < NV; i++) begin
      start_btn        = tbl[i].st;
      btn_valid        = tbl[i].bv;
      btn_colour       = exp_seq[{cur_idx, 1'b0} +: 2] ^ {1'b0, tbl[i].bad};
      complete_display = tbl[i].cd;
      cyc();
      start_btn        = 1'b0;
      btn_valid        = 1'b0;
      complete_display = 1'b0;
      chk($sformatf("vec%0d", i),
          64'({state_out, round_ctr, input_idx, en_display, game_over, game_win, rst_display}),
          64'({tbl[i].s, tbl[i].rnd, tbl[i].idx, tbl[i].en, tbl[i].ov, tbl[i].wn, 1'b0}));
      if (tbl[i].s == 3'd1) exp_seq = m_lfsr;
      else chk($sformatf("vec%0d_seq", i), 64'(seq_out), 64'(exp_seq));
      cur_idx = tbl[i].idx;
    end

    // Wrong colour in round 1 after one correct press.
    to_round1("wrong");
    press(exp_seq[1:0]);
    chk("wrong_idx1", 64'({state_out, input_idx}), 64'({3'd3, 4'd1}));
    press(exp_seq[3:2] ^ 2'b01);
    chk("wrong_over", 64'({state_out, game_over, game_win, round_ctr, input_idx}),
                      64'({3'd6, 1'b1, 1'b0, 4'd1, 4'd1}));
    press(exp_seq[3:2]);
    press(exp_seq[1:0]);
    chk("over_sticky", 64'({state_out, game_over, game_win, round_ctr, input_idx}),
                       64'({3'd6, 1'b1, 1'b0, 4'd1, 4'd1}));

    // Restart from GAME_OVER picks up a fresh sequence.
    start_game("restart_load");
    chk("restart_out", 64'({state_out, game_over, round_ctr, input_idx, en_display}),
                       64'({3'd2, 1'b0, 4'd0, 4'd0, 1'b1}));
    chk("restart_seq", 64'(seq_out), 64'(exp_seq));

    // Timeout: loss exactly 20 cycles after entering WAIT_INPUT.
    pulse_cd();
    repeat (19) cyc();
    chk("timeout_pre", 64'({state_out, game_over}), 64'({3'd3, 1'b0}));
    cyc();
    chk("timeout_hit", 64'({state_out, game_over, round_ctr}), 64'({3'd6, 1'b1, 4'd0}));

    // A correct press on the 20th cycle beats the timeout and restarts the timer.
    start_game("to2_load");
    to_round1("to2");
    repeat (19) cyc();
    chk("to2_pre", 64'(state_out), 64'd3);
    press(exp_seq[1:0]);
    chk("to2_press", 64'({state_out, input_idx, game_over}), 64'({3'd3, 4'd1, 1'b0}));
    repeat (19) cyc();
    chk("to2_timer_rst", 64'({state_out, game_over}), 64'({3'd3, 1'b0}));

    // Asynchronous reset in the middle of WAIT_INPUT, away from any clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    start_game("post_rst_load");
    chk("post_rst_seq", 64'(seq_out), 64'(exp_seq));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simon_game_ctrl.md
Name: simon_game_ctrl

Overview:
Top-level game sequencer for Simon Says. It generates the 32-bit colour sequence (16 × 2-bit colours, LSB-first) and drives display_state through its rst_display, en_display, seq_in_display and round_ctr inputs. It checks the player's button presses against the sequence, advances rounds and reports win or loss. It sits between the debounced button front-end and display_state.

Parameters:
TIMEOUT_CYCLES, 50_000_000, clk ticks allowed between player inputs before loss (≥2)
GAP_CYCLES, 2_500_000, pause between a correct round and the next display (≥1)
MAX_ROUND, 15, final round index (0..15); completing it wins the game

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
start_btn  input  1  1-cycle pulse; starts or restarts a game
btn_valid  input  1  1-cycle pulse; player pressed a colour
btn_colour  input  2  colour pressed, valid with btn_valid
complete_display  input  1  1-cycle done pulse from display_state
rst_display  output  1  sync reset to display_state, registered
en_display  output  1  start pulse to display_state, registered
seq_out  output  32  colour sequence to seq_in_display
round_ctr  output  4  current round N (N+1 colours), to display_state
input_idx  output  4  index of next expected player colour
game_over  output  1  sticky loss flag
game_win  output  1  sticky win flag
state_out  output  3  FSM state encoding, for debug/LEDs

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, async): state=IDLE(0), seq_out=0, round_ctr=0, input_idx=0, en_display=0, rst_display=1, game_over=0, game_win=0.
- LFSR: a 32-bit Galois LFSR steps every clk, independent of state.
  - Reset value 32'hACE1_2468.
  - Shift right; if the old bit0 is 1, XOR with 32'h8020_0003.
- State encoding: IDLE=0, LOAD=1, DISPLAY=2, WAIT_INPUT=3, ROUND_DONE=4, GAP=5, GAME_OVER=6, GAME_WIN=7.
- IDLE: rst_display=1. On start_btn, go to LOAD.
- LOAD (1 cycle):
  - seq_out<=lfsr, round_ctr<=0, input_idx<=0.
  - game_over<=0, game_win<=0.
  - rst_display<=0; it stays 0 in every state except IDLE.
  - Next state: DISPLAY.
- DISPLAY:
  - en_display=1 only on the first cycle in this state (one pulse per entry), else 0.
  - Wait for complete_display, then go to WAIT_INPUT with timer<=0 and input_idx<=0.
  - btn_valid is ignored.
- WAIT_INPUT: timer increments each cycle. Expected colour = seq_out[2*input_idx +: 2].
  - btn_valid with a match and input_idx==round_ctr: go to ROUND_DONE.
  - btn_valid with a match and input_idx<round_ctr: input_idx++, timer<=0.
  - btn_valid with a mismatch: go to GAME_OVER.
  - timer==TIMEOUT_CYCLES-1 and no btn_valid: go to GAME_OVER.
  - btn_valid and timeout in the same cycle: btn_valid takes priority.
- ROUND_DONE (1 cycle):
  - If round_ctr==MAX_ROUND, go to GAME_WIN.
  - Else round_ctr++, input_idx<=0, timer<=0, go to GAP.
- GAP: count GAP_CYCLES cycles, then go to DISPLAY. round_ctr is stable throughout DISPLAY and WAIT_INPUT.
- GAME_OVER: game_over=1 (sticky). round_ctr holds the failed round as the score.
- GAME_WIN: game_win=1 (sticky). round_ctr holds MAX_ROUND.
- GAME_OVER / GAME_WIN exit: on start_btn go to LOAD. game_over and game_win are never both 1.
- Pulse filtering:
  - start_btn is ignored in LOAD, DISPLAY, WAIT_INPUT, ROUND_DONE and GAP (no mid-game restart).
  - btn_valid is ignored outside WAIT_INPUT.
  - complete_display is ignored outside DISPLAY.
- rst_n asserted mid-game: immediate return to the reset values above. The LFSR also resets.
- Counters: input_idx and round_ctr are 4 bits and never wrap, because MAX_ROUND ≤ 15 bounds both. timer and gap counter widths are $clog2 of their parameters, each at least 1 bit.

Test Plan:
(All with TIMEOUT_CYCLES=20, GAP_CYCLES=4, MAX_ROUND=2.)
1. Reset, then start_btn → LOAD for 1 cycle. seq_out equals the LFSR value at that edge, round_ctr=0, then exactly one en_display pulse. Model complete_display 6 cycles later → state_out=3.
2. Full win: in each round k, answer colours 0..k from seq_out[2i+:2]. Expect round_ctr 0→1→2, one en_display per round, the GAP state lasting 4 cycles, then game_win=1, state_out=7, round_ctr=2.
3. Wrong colour: in round 1, correct input_idx 0, then press seq_out[3:2]^2'b01 → game_over=1, round_ctr=1, input_idx=1. Further btn_valid pulses cause no change.
4. Timeout: enter WAIT_INPUT and give no input → game_over asserts exactly 20 cycles after entry. With btn_valid (correct) on cycle 20 instead → no loss, input_idx advances.
5. Filtering: start_btn during DISPLAY and WAIT_INPUT is ignored. btn_valid during DISPLAY does not change input_idx. Spurious complete_display in WAIT_INPUT is ignored. From GAME_OVER, start_btn → game_over=0, round_ctr=0, new seq_out.
6. Async reset: drive rst_n=0 mid-WAIT_INPUT, off a clock edge → all outputs take reset values immediately, rst_display=1, state_out=0.
